// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit data-memory port.
// Holds the request op field layout, the FSM state encoding and the
// default memory geometry used by lsu_dm_port and lsu_lane.
package lsu_pkg;

    // Memory geometry defaults
    localparam int unsigned ADDR_W_DEF = 14;
    localparam int unsigned DM_BYTES   = 12288;

    // req_op field layout: [3]=store, [2]=unsigned, [1:0]=size
    localparam int unsigned OP_W     = 4;
    localparam int unsigned OP_STORE = 3;
    localparam int unsigned OP_UNS   = 2;

    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b10;
    localparam logic [1:0] SIZE_ILL = 2'b11;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // Alignment / legality check for a request size against the low address bits
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_H:  bad = lane[0];
            SIZE_W:  bad = (lane != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering for the load/store unit (purely combinational).
// Ports:
//   word      - 32-bit memory word read from the data memory
//   lane      - byte address bits [1:0]
//   size      - access size (SIZE_B / SIZE_H / SIZE_W)
//   uns       - zero-extend loads when set, sign-extend otherwise
//   wdata     - low half of the store data (byte stores use [7:0])
//   load_data - selected and extended load result
//   merged    - word with the store byte/half inserted at the addressed lane
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        lane,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [15:0]       wdata,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Little-endian lane select: byte k lives in bits 8k+7:8k
    always_comb begin
        byte_sel = word[7:0];
        case (lane)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = lane[1] ? word[31:16] : word[15:0];
    end

    // Load extension
    always_comb begin
        load_data = word;
        case (size)
            SIZE_B: load_data = uns ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SIZE_H: load_data = uns ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_data = word;
        endcase
    end

    // Read-modify-write merge; untouched lanes keep the memory contents
    always_comb begin
        merged = word;
        case (size)
            SIZE_B: begin
                case (lane)
                    2'd0: merged[7:0]   = wdata[7:0];
                    2'd1: merged[15:8]  = wdata[7:0];
                    2'd2: merged[23:16] = wdata[7:0];
                    2'd3: merged[31:24] = wdata[7:0];
                    default: merged = word;
                endcase
            end
            SIZE_H: begin
                if (lane[1]) merged[31:16] = wdata;
                else         merged[15:0]  = wdata;
            end
            default: merged = word;
        endcase
    end

endmodule

// File: rtl/lsu_dm_port.sv
// Load/store unit, initiator side of the word-wide data-memory port.
// Accepts one request at a time, checks alignment/range, performs loads
// with extension and sub-word stores as read-modify-write.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   req_valid/req_ready      - request handshake (ready only in IDLE)
//   req_op/req_addr/req_wdata- request op, byte address, store data
//   resp_valid/resp_ready    - response handshake (held until accepted)
//   resp_rdata/resp_err      - extended load data / error flag
//   dm_addr/dm_din/dm_we     - word-aligned address, write data, write enable
//   dm_dout                  - combinational memory read data
module lsu_dm_port
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DM_BYTES = lsu_pkg::DM_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_din,
    output logic              dm_we,
    input  logic [DATA_W-1:0] dm_dout
);

    lsu_state_e        state_q, state_d;
    logic [OP_W-1:0]   op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [DATA_W-1:0] word_q;

    logic              accept;
    logic              req_err;
    logic              req_store;
    logic [DATA_W-1:0] lane_load;
    logic [DATA_W-1:0] lane_merged;

    assign accept    = req_valid && req_ready;
    assign req_store = req_op[OP_STORE];

    // Request legality: illegal size, misalignment, or address beyond memory
    always_comb begin
        req_err = 1'b0;
        if (req_op[1:0] == SIZE_ILL)                    req_err = 1'b1;
        if (misaligned(req_op[1:0], req_addr[1:0]))     req_err = 1'b1;
        if (req_addr >= 32'(DM_BYTES))                  req_err = 1'b1;
    end

    lsu_lane u_lane (
        .word      (dm_dout),
        .lane      (addr_q[1:0]),
        .size      (op_q[1:0]),
        .uns       (op_q[OP_UNS]),
        .wdata     (wdata_q),
        .load_data (lane_load),
        .merged    (lane_merged)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err)                     state_d = ST_RESP;
                    else if (!req_store)             state_d = ST_READ;
                    else if (req_op[1:0] == SIZE_W)  state_d = ST_WRITE;
                    else                             state_d = ST_READ;
                end
            end
            ST_READ:  state_d = op_q[OP_STORE] ? ST_WRITE : ST_RESP;
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  if (resp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State, handshake flags and latched request/response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            req_ready  <= (state_d == ST_IDLE);
            resp_valid <= (state_d == ST_RESP);
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q       <= req_op;
                        addr_q     <= req_addr[ADDR_W-1:0];
                        wdata_q    <= req_wdata[15:0];
                        word_q     <= req_wdata;
                        resp_err   <= req_err;
                        resp_rdata <= '0;
                    end
                end
                ST_READ: begin
                    if (op_q[OP_STORE]) begin
                        word_q <= lane_merged;
                    end else begin
                        word_q     <= dm_dout;
                        resp_rdata <= lane_load;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dm_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign dm_din  = word_q;
    // Gated by rst so a reset during WRITE leaves memory untouched
    assign dm_we   = (state_q == ST_WRITE) && !rst;

endmodule

// File: tb/tb_lsu_dm_port.sv
module tb_lsu_dm_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [13:0] dm_addr;
    logic [31:0] dm_din;
    logic        dm_we;
    logic [31:0] dm_dout;

    int passed = 0;
    int total  = 0;

    logic [31:0] mem [0:3071];
    int          we_count = 0;
    logic [31:0] last_din = '0;
    logic [11:0] widx;

    always #5 clk = ~clk;

    lsu_dm_port dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dm_addr    (dm_addr),
        .dm_din     (dm_din),
        .dm_we      (dm_we),
        .dm_dout    (dm_dout)
    );

    assign widx    = dm_addr[13:2];
    assign dm_dout = (widx < 12'd3072) ? mem[widx] : 32'h0;

    always @(posedge clk) begin
        if (dm_we) begin
            if (widx < 12'd3072) mem[widx] <= dm_din;
            we_count = we_count + 1;
            last_din = dm_din;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_we;
        logic [31:0] exp_din;
    } vec_t;

    vec_t vecs [17];

    task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        int guard;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 20);
        rd = resp_rdata;
        er = resp_err;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          we0;

        for (int i = 0; i < 3072; i++) mem[i] = 32'h0;
        mem[4] = 32'h8899AABB;

        //            name        op     addr          wdata          rdata          err  lat we  din
        vecs[0]  = '{"lw_10",    4'h2, 32'h10,       32'h0,         32'h8899AABB, 1'b0, 2, 0, 32'h0};
        vecs[1]  = '{"lb_13",    4'h0, 32'h13,       32'h0,         32'hFFFFFF88, 1'b0, 2, 0, 32'h0};
        vecs[2]  = '{"lbu_13",   4'h4, 32'h13,       32'h0,         32'h00000088, 1'b0, 2, 0, 32'h0};
        vecs[3]  = '{"lh_12",    4'h1, 32'h12,       32'h0,         32'hFFFF8899, 1'b0, 2, 0, 32'h0};
        vecs[4]  = '{"lhu_10",   4'h5, 32'h10,       32'h0,         32'h0000AABB, 1'b0, 2, 0, 32'h0};
        vecs[5]  = '{"lb_10",    4'h0, 32'h10,       32'h0,         32'hFFFFFFBB, 1'b0, 2, 0, 32'h0};
        vecs[6]  = '{"sb_11",    4'h8, 32'h11,       32'h123456CC,  32'h0,        1'b0, 3, 1, 32'h8899CCBB};
        vecs[7]  = '{"lw_10b",   4'h2, 32'h10,       32'h0,         32'h8899CCBB, 1'b0, 2, 0, 32'h0};
        vecs[8]  = '{"sh_12",    4'h9, 32'h12,       32'hABCD7777,  32'h0,        1'b0, 3, 1, 32'h7777CCBB};
        vecs[9]  = '{"lhu_12",   4'h5, 32'h12,       32'h0,         32'h00007777, 1'b0, 2, 0, 32'h0};
        vecs[10] = '{"lw_mis",   4'h2, 32'h12,       32'h0,         32'h0,        1'b1, 1, 0, 32'h0};
        vecs[11] = '{"sh_mis",   4'h9, 32'h11,       32'h5555,      32'h0,        1'b1, 1, 0, 32'h0};
        vecs[12] = '{"sw_oor",   4'hA, 32'd12288,    32'h12345678,  32'h0,        1'b1, 1, 0, 32'h0};
        vecs[13] = '{"size11",   4'h3, 32'h10,       32'h0,         32'h0,        1'b1, 1, 0, 32'h0};
        vecs[14] = '{"hi_addr",  4'h2, 32'h00010010, 32'h0,         32'h0,        1'b1, 1, 0, 32'h0};
        vecs[15] = '{"sw_24",    4'hA, 32'h24,       32'hCAFEF00D,  32'h0,        1'b0, 2, 1, 32'hCAFEF00D};
        vecs[16] = '{"lw_24",    4'h2, 32'h24,       32'h0,         32'hCAFEF00D, 1'b0, 2, 0, 32'h0};

        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready",  32'(req_ready),  32'h1);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_rdata",      resp_rdata,      32'h0);
        check("rst_err",        32'(resp_err),   32'h0);
        check("rst_dm_we",      32'(dm_we),      32'h0);
        check("rst_dm_addr",    32'(dm_addr),    32'h0);
        check("rst_dm_din",     dm_din,          32'h0);

        for (int i = 0; i < 17; i++) begin
            we0 = we_count;
            do_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
            check({vecs[i].name, "_err"},   32'(er), 32'(vecs[i].exp_err));
            check({vecs[i].name, "_lat"},   32'(lat), 32'(vecs[i].exp_lat));
            check({vecs[i].name, "_we"},    32'(we_count - we0), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we != 0) check({vecs[i].name, "_din"}, last_din, vecs[i].exp_din);
        end

        // Backpressure: hold resp_ready low while another request waits
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'h2; req_addr = 32'h10; req_wdata = '0;
        @(posedge clk);
        #1 req_op = 4'h4;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 20);
        check("hold_lat", 32'(lat), 32'd2);
        for (int c = 0; c < 5; c++) begin
            check("hold_valid", 32'(resp_valid), 32'h1);
            check("hold_rdata", resp_rdata,      32'h7777CCBB);
            check("hold_ready", 32'(req_ready),  32'h0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        check("hs_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("next_not_yet", 32'(resp_valid), 32'h0);
        @(negedge clk);
        check("next_valid", 32'(resp_valid), 32'h1);
        check("next_rdata", resp_rdata,      32'h000000BB);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;

        // Reset while in WRITE of sw 0xDEADBEEF @0x20
        we0 = we_count;
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'hA; req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("wr_state_we", 32'(dm_we), 32'h1);
        rst = 1'b1;
        #1 check("rst_gate_we", 32'(dm_we), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_no_write",   32'(we_count - we0), 32'h0);
        check("rst_mem_20",     mem[8],          32'h0);
        check("rst2_req_ready", 32'(req_ready),  32'h1);
        check("rst2_valid",     32'(resp_valid), 32'h0);
        check("rst2_rdata",     resp_rdata,      32'h0);
        check("rst2_err",       32'(resp_err),   32'h0);
        check("rst2_dm_we",     32'(dm_we),      32'h0);
        check("rst2_dm_addr",   32'(dm_addr),    32'h0);
        check("rst2_dm_din",    dm_din,          32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lsu_dm_port.md
Name: lsu_dm_port

Overview:
- Load/store unit: the initiator side of the data-memory port.
- Accepts one CPU memory request at a time (lb/lbu/lh/lhu/lw/sb/sh/sw) and drives the word-wide byte-addressed data memory (14-bit byte address, 32-bit din/dout, combinational read, write on posedge clk when we).
- Performs alignment and range checks, and sign or zero extension on loads.
- Implements sub-word stores as read-modify-write, because the memory writes only whole words.
- Sits between the multicycle datapath's MEM stage and the data memory.

Parameters:
- ADDR_W, 14, memory byte-address width.
- DM_BYTES, 12288, number of valid bytes; addresses at or above this are out of range.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_op  in  4  [3]=store, [2]=unsigned (loads only), [1:0]=size: 00 byte, 01 half, 10 word, 11 illegal.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte or half is used for sb/sh.
- resp_valid  out  1  response held until accepted.
- resp_ready  in  1  datapath accepts response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, out of range, or illegal size.
- dm_addr  out  ADDR_W  word-aligned address: {addr_q[ADDR_W-1:2],2'b00}.
- dm_din  out  32  write data to memory.
- dm_we  out  1  memory write enable.
- dm_dout  in  32  memory read data, combinational from dm_addr.

Behaviour:
- States: IDLE, READ, WRITE, RESP. Reset → IDLE.
- Reset values:
  - req_ready=1.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - dm_we=0, dm_addr=0, dm_din=0.
  - All latched request registers 0.
- IDLE, on req_valid&&req_ready: latch op, addr, wdata. Evaluate error in the same cycle:
  - size==11;
  - half with addr[0]!=0;
  - word with addr[1:0]!=0;
  - addr >= DM_BYTES, or addr[31:ADDR_W]!=0.
- On error: go to RESP with resp_err=1 and rdata=0. No memory access occurs and dm_we is never asserted.
- Next state when there is no error:
  - Load → READ.
  - sw → WRITE.
  - sb/sh → READ.
- READ, one cycle. Sample dm_dout into word_q.
  - Load: select the byte or half by addr_q[1:0] (little-endian; byte k = bits 8k+7:8k). Sign-extend, or zero-extend if op[2]. Go to RESP.
  - sb/sh: merge the low byte/half of wdata into word_q at the addressed lane, other lanes unchanged. Go to WRITE.
- WRITE, one cycle. dm_we = (state==WRITE) && !rst, combinational from state. dm_din = the merged word (or wdata for sw). The memory commits at the edge leaving WRITE. Go to RESP with rdata=0.
- RESP: resp_valid=1; rdata and err stay stable until resp_ready. On resp_valid&&resp_ready → IDLE.
- req_ready is 0 outside IDLE. A request arriving in RESP is not accepted until the cycle after the handshake; no bypass.
- Latency, request accept to resp_valid:
  - lw/lh/lb: 2 cycles.
  - sw: 2 cycles.
  - sb/sh: 3 cycles.
  - Error: 1 cycle.
- Reset mid-operation: rst in any state → IDLE at the next edge and response is discarded. In WRITE, the !rst gating suppresses the write at that edge, so memory is untouched.
- dm_addr is driven from addr_q in all states. It is never out of range when dm_we=1.

Decomposition:
- Shared package lsu_pkg holds:
  - the op field encodings (SIZE_B/SIZE_H/SIZE_W, OP_STORE bit, OP_UNS bit);
  - the state encoding;
  - DM_BYTES.
- One natural sub-module: lsu_lane (combinational). Inputs are word, addr[1:0], size and unsigned. Outputs are the extended load data and the merged store word. It is shared by READ for loads and by the RMW merge.

Test Plan:
- Preload word @0x10=0x8899AABB.
  - lw 0x10 → resp_rdata=0x8899AABB, err=0, resp_valid 2 cycles after accept.
- Same word.
  - lb 0x13 → 0xFFFFFF88.
  - lbu 0x13 → 0x00000088.
  - lh 0x12 → 0xFFFF8899.
  - lhu 0x10 → 0x0000AABB.
- sb wdata=0x123456CC at 0x11 → dm_we high exactly one cycle with dm_din=0x8899CCBB. lw 0x10 then returns 0x8899CCBB; latency 3.
- Misaligned or out-of-range requests → resp_err=1, rdata=0, dm_we never high.
  - lw 0x12.
  - sh 0x11.
  - sw 12288.
  - op size 11.
- Hold resp_ready=0 for 5 cycles after lw → resp_valid/rdata stable and req_ready=0 with req_valid held high. Handshake → next request accepted the following cycle.
- Assert rst during WRITE of sw 0xDEADBEEF @0x20 (previously 0) → dm_we low that cycle, word stays 0, unit in IDLE with all outputs at reset values.
